n101_reset_req_gen: RTL and testbench



---
 rtl/n101_reset_req_gen.sv | 119 +++++++++++
 tb/tb_n101_reset_req_gen.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n101_reset_req_gen.sv
// Reset-request generator: merges sw/wdt/dbg requests into a registered rst_req pulse
// of fixed minimum width followed by a hold-off gap, and keeps a sticky cause register.
module n101_reset_req_gen #(
  parameter int PULSE_CYCLES   = 16,
  parameter int HOLDOFF_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       test_mode,
  input  logic       sw_rst_req,
  input  logic       wdt_rst_req,
  input  logic       dbg_rst_req,
  input  logic       cause_clr,
  output logic       rst_req,
  output logic [3:0] rst_cause,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sw_pend_q, sw_pend_d;
  logic             rst_req_q, rst_req_d;
  logic             busy_q, busy_d;
  logic [3:0]       cause_q, cause_d;
  logic             any_req;

  assign any_req = sw_rst_req | sw_pend_q | wdt_rst_req | dbg_rst_req;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sw_pend_d = sw_pend_q;
    cause_d   = cause_q;

    if (test_mode) begin
      state_d   = IDLE;
      cnt_d     = '0;
      sw_pend_d = 1'b0;
    end else begin
      // Clear first so that a same-cycle set wins per bit; por bit only comes from reset.
      if (cause_clr) begin
        cause_d = 4'b0000;
      end
      cause_d[2:0] = cause_d[2:0] | {dbg_rst_req, wdt_rst_req, sw_rst_req};

      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            state_d   = ASSERT;
            cnt_d     = PULSE_LOAD;
            sw_pend_d = 1'b0;
          end
        end
        ASSERT: begin
          if (sw_rst_req) begin
            sw_pend_d = 1'b1;
          end
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (!dbg_rst_req) begin
            state_d = HOLDOFF;
            cnt_d   = HOLDOFF_LOAD;
          end
        end
        HOLDOFF: begin
          if (sw_rst_req) begin
            sw_pend_d = 1'b1;
          end
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    rst_req_d = (state_d == ASSERT);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sw_pend_q <= 1'b0;
      rst_req_q <= 1'b0;
      busy_q    <= 1'b0;
      cause_q   <= 4'b1000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sw_pend_q <= sw_pend_d;
      rst_req_q <= rst_req_d;
      busy_q    <= busy_d;
      cause_q   <= cause_d;
    end
  end

  // test_mode is the only input allowed to reach an output combinationally.
  assign rst_req   = rst_req_q & ~test_mode;
  assign busy      = busy_q;
  assign rst_cause = cause_q;

endmodule

// File: tb/tb_n101_reset_req_gen.sv
// Directed bench for n101_reset_req_gen: pulse width, hold-off, stretch, cause register,
// test mode and asynchronous reset. Observations are taken 1 time unit after each edge.
module tb_n101_reset_req_gen;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       test_mode = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       wdt_rst_req = 1'b0;
  logic       dbg_rst_req = 1'b0;
  logic       cause_clr = 1'b0;
  logic       rst_req;
  logic [3:0] rst_cause;
  logic       busy;

  int checks = 0;
  int errors = 0;

  n101_reset_req_gen #(
    .PULSE_CYCLES(16),
    .HOLDOFF_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .test_mode  (test_mode),
    .sw_rst_req (sw_rst_req),
    .wdt_rst_req(wdt_rst_req),
    .dbg_rst_req(dbg_rst_req),
    .cause_clr  (cause_clr),
    .rst_req    (rst_req),
    .rst_cause  (rst_cause),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max_cycles) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
    step();
  endtask

  task automatic clear_cause();
    cause_clr = 1'b1;
    step();
    cause_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    checks++;
    if (rst_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_rst_req got %b required 0", rst_req);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b required 0", busy);
    end
    checks++;
    if (rst_cause !== 4'b1000) begin
      errors++;
      $display("FAIL reset_cause got %b required 1000", rst_cause);
    end
    clear_cause();
    checks++;
    if (rst_cause !== 4'b0000) begin
      errors++;
      $display("FAIL cause_clr got %b required 0000", rst_cause);
    end
  endtask

  task automatic test_sw_request();
    logic exp_rq, exp_busy;
    for (int e = 0; e < 22; e++) begin
      sw_rst_req = (e == 0);
      step();
      exp_rq   = (e <= 15);
      exp_busy = (e <= 19);
      checks++;
      if (rst_req !== exp_rq) begin
        errors++;
        $display("FAIL sw_pulse_rst_req e=%0d got %b required %b", e, rst_req, exp_rq);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL sw_pulse_busy e=%0d got %b required %b", e, busy, exp_busy);
      end
    end
    sw_rst_req = 1'b0;
    checks++;
    if (rst_cause !== 4'b0001) begin
      errors++;
      $display("FAIL sw_cause got %b required 0001", rst_cause);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_rq, exp_busy;
    clear_cause();
    for (int e = 0; e < 43; e++) begin
      sw_rst_req = (e == 0) || (e == 5);
      step();
      exp_rq   = (e <= 15) || (e >= 21 && e <= 36);
      exp_busy = (e <= 19) || (e >= 21 && e <= 40);
      checks++;
      if (rst_req !== exp_rq) begin
        errors++;
        $display("FAIL b2b_rst_req e=%0d got %b required %b", e, rst_req, exp_rq);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL b2b_busy e=%0d got %b required %b", e, busy, exp_busy);
      end
    end
    sw_rst_req = 1'b0;
  endtask

  task automatic test_dbg_stretch();
    logic exp_rq, exp_busy;
    clear_cause();
    for (int e = 0; e < 37; e++) begin
      dbg_rst_req = (e <= 29);
      step();
      exp_rq   = (e <= 29);
      exp_busy = (e <= 33);
      checks++;
      if (rst_req !== exp_rq) begin
        errors++;
        $display("FAIL dbg_rst_req e=%0d got %b required %b", e, rst_req, exp_rq);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL dbg_busy e=%0d got %b required %b", e, busy, exp_busy);
      end
    end
    dbg_rst_req = 1'b0;
    checks++;
    if (rst_cause !== 4'b0100) begin
      errors++;
      $display("FAIL dbg_cause got %b required 0100", rst_cause);
    end
  endtask

  task automatic test_wdt_clr_collision();
    wdt_rst_req = 1'b1;
    cause_clr   = 1'b1;
    step();
    wdt_rst_req = 1'b0;
    cause_clr   = 1'b0;
    checks++;
    if (rst_cause !== 4'b0010) begin
      errors++;
      $display("FAIL wdt_clr_cause got %b required 0010", rst_cause);
    end
    checks++;
    if (rst_req !== 1'b1) begin
      errors++;
      $display("FAIL wdt_rst_req got %b required 1", rst_req);
    end
    wait_idle(60);
  endtask

  task automatic test_test_mode();
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    clear_cause();
    checks++;
    if (rst_req !== 1'b1 || rst_cause !== 4'b0000) begin
      errors++;
      $display("FAIL tm_pre got rst_req=%b cause=%b required 1/0000", rst_req, rst_cause);
    end
    test_mode   = 1'b1;
    wdt_rst_req = 1'b1;
    #1;
    checks++;
    if (rst_req !== 1'b0) begin
      errors++;
      $display("FAIL tm_comb_rst_req got %b required 0", rst_req);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL tm_busy_registered got %b required 1", busy);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL tm_idle_busy got %b required 0", busy);
    end
    step();
    checks++;
    if (rst_cause !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tm_ignore got cause=%b busy=%b required 0000/0", rst_cause, busy);
    end
    test_mode   = 1'b0;
    wdt_rst_req = 1'b0;
    step();
    checks++;
    if (rst_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tm_release got rst_req=%b busy=%b required 0/0", rst_req, busy);
    end
  endtask

  task automatic test_reset_mid_pulse();
    clear_cause();
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (rst_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_rst_req got %b required 1", rst_req);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (rst_req !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_rst_req got %b required 0", rst_req);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_busy got %b required 0", busy);
    end
    checks++;
    if (rst_cause !== 4'b1000) begin
      errors++;
      $display("FAIL mid_async_cause got %b required 1000", rst_cause);
    end
    step();
    reset = 1'b0;
    step();
    step();
    checks++;
    if (rst_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_after got rst_req=%b busy=%b required 0/0", rst_req, busy);
    end
  endtask

  initial begin
    test_reset();
    test_sw_request();
    test_back_to_back();
    test_dbg_stretch();
    test_wdt_clr_collision();
    test_test_mode();
    test_reset_mid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
